// File: rtl/mult16_share_pkg.sv
// Shared types and constants for the mult16 sharing controller.
// Holds the requester state encoding, operand/product widths, default
// parameter values and the owner tag that rides alongside the core pipe.
package mult16_share_pkg;
  localparam int OP_W         = 16;
  localparam int PROD_W       = 32;
  localparam int NREQ_DEF     = 4;
  localparam int MULT_LAT_DEF = 2;
  // Tag index sized for the largest supported NREQ (8).
  localparam int TAG_IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } req_state_e;

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/mult16_share_ctrl_if.sv
// Bus bundle for mult16_share_ctrl: requester operands, responses and the
// issue/return path to the shared multiplier core. Vectors are flat and
// packed per requester (requester i at [W*i +: W]).
//   slave  : the controller side
//   master : the clients + core side
interface mult16_share_ctrl_if import mult16_share_pkg::*; #(
  parameter int NREQ = NREQ_DEF
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OP_W-1:0]   req_a;
  logic [NREQ*OP_W-1:0]   req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ*PROD_W-1:0] rsp_p;
  logic                   mult_in_valid;
  logic [OP_W-1:0]        mult_a;
  logic [OP_W-1:0]        mult_b;
  logic [PROD_W-1:0]      mult_p;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mult_p,
    output req_ready, rsp_valid, rsp_p, mult_in_valid, mult_a, mult_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mult_p,
    input  req_ready, rsp_valid, rsp_p, mult_in_valid, mult_a, mult_b
  );
endinterface

// File: rtl/mult16_rr_arbiter.sv
// Combinational round-robin arbiter. Searches eligible starting at
// rr_ptr+1 and wrapping, so the last winner has lowest priority.
//   eligible : per-requester request qualified by idle state
//   rr_ptr   : index of the most recent winner
//   grant    : one-hot winner (zero if nothing eligible)
//   gnt_idx  : encoded winner index
//   gnt_vld  : some requester won
module mult16_rr_arbiter import mult16_share_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c       = 0;
    ci      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c  = (int'(rr_ptr) + k) % NREQ;
      ci = IDX_W'(c);
      if (!gnt_vld && eligible[ci]) begin
        gnt_vld   = 1'b1;
        grant[ci] = 1'b1;
        gnt_idx   = ci;
      end
    end
  end
endmodule

// File: rtl/mult16_share_ctrl.sv
// Shares one pipelined 16x16 signed multiplier core among NREQ requesters.
// Round-robin grants at most one operation per cycle, registers the issue
// to the core, carries an owner tag down a MULT_LAT-deep pipe and parks the
// returning product in a per-requester response buffer until handshaken.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus              : req/rsp handshakes and core issue/return (slave)
//   perf_issue_cnt, perf_stall_cnt : saturating counters, present only
//                      when MULT16_SHARE_PERF_EN is defined
module mult16_share_ctrl import mult16_share_pkg::*; #(
  parameter int NREQ     = NREQ_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  mult16_share_ctrl_if.slave bus
`ifdef MULT16_SHARE_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  req_state_e                  state_q [NREQ];
  req_state_e                  state_d [NREQ];
  logic [NREQ-1:0]             eligible, grant, accept;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        gnt_vld, acc_any;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic                        mult_vld_q, mult_vld_d;
  logic [OP_W-1:0]             mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [NREQ-1:0][PROD_W-1:0] rsp_p_q, rsp_p_d;
  // Stage 0 is the issue register; stage MULT_LAT lines up with mult_p.
  tag_t                        tag_pipe_q [MULT_LAT+1];
  tag_t                        tag_pipe_d [MULT_LAT+1];
  tag_t                        cap;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign eligible[i]      = bus.req_valid[i] & (state_q[i] == IDLE);
    assign bus.rsp_valid[i] = (state_q[i] == DONE);
  end

  mult16_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Nothing is accepted while reset is held.
  assign accept        = grant & ~{NREQ{sys_rst}};
  assign acc_any       = gnt_vld & ~sys_rst;
  assign bus.req_ready = accept;
  assign cap           = tag_pipe_q[MULT_LAT];

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    mult_vld_d    = acc_any;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    tag_pipe_d[0] = '0;
    if (acc_any) begin
      rr_ptr_d          = gnt_idx;
      mult_a_d          = bus.req_a[gnt_idx*OP_W +: OP_W];
      mult_b_d          = bus.req_b[gnt_idx*OP_W +: OP_W];
      tag_pipe_d[0].vld = 1'b1;
      tag_pipe_d[0].idx = TAG_IDX_W'(gnt_idx);
    end
    for (int k = 1; k <= MULT_LAT; k++) tag_pipe_d[k] = tag_pipe_q[k-1];

    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      rsp_p_d[i] = rsp_p_q[i];
      case (state_q[i])
        IDLE:     if (accept[i]) state_d[i] = INFLIGHT;
        INFLIGHT: if (cap.vld && cap.idx == TAG_IDX_W'(i)) begin
                    state_d[i] = DONE;
                    rsp_p_d[i] = bus.mult_p;
                  end
        DONE:     if (bus.rsp_ready[i]) state_d[i] = IDLE;
        default:  state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_ptr_q   <= IDX_W'(NREQ - 1);
      mult_vld_q <= 1'b0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      rsp_p_q    <= '0;
      for (int k = 0; k <= MULT_LAT; k++) tag_pipe_q[k] <= '0;
      for (int i = 0; i < NREQ; i++) state_q[i] <= IDLE;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      mult_vld_q <= mult_vld_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      rsp_p_q    <= rsp_p_d;
      for (int k = 0; k <= MULT_LAT; k++) tag_pipe_q[k] <= tag_pipe_d[k];
      for (int i = 0; i < NREQ; i++) state_q[i] <= state_d[i];
    end
  end

  assign bus.mult_in_valid = mult_vld_q;
  assign bus.mult_a        = mult_a_q;
  assign bus.mult_b        = mult_b_q;
  assign bus.rsp_p         = rsp_p_q;

`ifdef MULT16_SHARE_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (acc_any && perf_issue_q != '1) perf_issue_d = perf_issue_q + 32'd1;
    if ((|bus.req_valid) && !gnt_vld && perf_stall_q != '1)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_mult16_share_ctrl.sv
// Randomized scoreboard bench for mult16_share_ctrl. Expected products are
// queued per requester at accept time and popped by a monitor on each
// response handshake; the monitor also models round-robin grant order,
// issue timing, response latency, stability and reset behaviour.
module tb_mult16_share_ctrl;
  localparam int NREQ     = 4;
  localparam int MULT_LAT = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  mult16_share_ctrl_if #(.NREQ(NREQ)) bus ();

  logic [NREQ-1:0]       va, rdy;
  logic [NREQ-1:0][15:0] aa, ba;
  assign bus.req_valid = va;
  assign bus.req_a     = aa;
  assign bus.req_b     = ba;
  assign bus.rsp_ready = rdy;

`ifdef MULT16_SHARE_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  mult16_share_ctrl #(.NREQ(NREQ), .MULT_LAT(MULT_LAT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
`ifdef MULT16_SHARE_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Behavioural core: product emerges MULT_LAT cycles after the operands.
  logic [31:0] core_pipe [MULT_LAT+1];
  always @(posedge sys_clk) begin
    core_pipe[1] <= smul(bus.mult_a, bus.mult_b);
    for (int k = 2; k <= MULT_LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign bus.mult_p = core_pipe[MULT_LAT];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model state
  logic [31:0]     exp_q [NREQ][$];
  logic [NREQ-1:0] busy, seen, hold;
  logic [31:0]     hold_p [NREQ];
  int              acc_cyc [NREQ];
  int              rr, cyc;
  bit              rst_prev, prev_acc;
  logic [15:0]     last_a, last_b;
  int              m_issue, m_stall;

  always @(negedge sys_clk) begin
    logic [NREQ-1:0] elig, egnt, acc;
    logic [31:0]     rp;
    int c;
    cyc++;
    if (sys_rst) begin
      chk("req_ready_in_reset", bus.req_ready, '0);
      if (rst_prev) begin
        chk("rst_rsp_valid", bus.rsp_valid, '0);
        chk("rst_mult_in_valid", bus.mult_in_valid, 0);
        chk("rst_mult_a", bus.mult_a, 0);
        chk("rst_mult_b", bus.mult_b, 0);
        chk("rst_rsp_p", bus.rsp_p, 0);
`ifdef MULT16_SHARE_PERF_EN
        chk("rst_perf_issue", perf_issue_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
`endif
      end
      rst_prev = 1; busy = '0; seen = '0; hold = '0;
      rr = NREQ - 1; prev_acc = 0; last_a = '0; last_b = '0;
      m_issue = 0; m_stall = 0;
      for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    end else begin
      rst_prev = 0;
      chk("issue_valid", bus.mult_in_valid, prev_acc);
      chk("issue_a", bus.mult_a, last_a);
      chk("issue_b", bus.mult_b, last_b);
`ifdef MULT16_SHARE_PERF_EN
      chk("perf_issue", perf_issue_cnt, m_issue);
      chk("perf_stall", perf_stall_cnt, m_stall);
`endif
      elig = bus.req_valid & ~busy;
      egnt = '0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (rr + k) % NREQ;
        if (egnt == '0 && elig[c]) egnt[c] = 1'b1;
      end
      chk("grant", bus.req_ready, egnt);
      acc = bus.req_valid & bus.req_ready;

      for (int i = 0; i < NREQ; i++) begin
        rp = bus.rsp_p[32*i +: 32];
        if (bus.rsp_valid[i]) begin
          if (!busy[i]) chk("rsp_valid_without_op", bus.rsp_valid[i], 0);
          else begin
            if (!seen[i]) begin
              chk("rsp_latency", cyc - acc_cyc[i], MULT_LAT + 2);
              seen[i] = 1'b1;
            end
            if (hold[i]) chk("rsp_p_stable", rp, hold_p[i]);
            if (bus.rsp_ready[i]) begin
              chk("rsp_p", rp, exp_q[i].pop_front());
              busy[i] = 1'b0;
              hold[i] = 1'b0;
            end else begin
              hold[i]   = 1'b1;
              hold_p[i] = rp;
            end
          end
        end else begin
          if (hold[i]) begin
            chk("rsp_valid_dropped", bus.rsp_valid[i], 1);
            hold[i] = 1'b0;
          end
          if (busy[i] && !seen[i] && (cyc - acc_cyc[i]) > MULT_LAT + 2) begin
            chk("rsp_late", bus.rsp_valid[i], 1);
            seen[i] = 1'b1;
          end
        end
      end

      prev_acc = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          busy[i]    = 1'b1;
          seen[i]    = 1'b0;
          acc_cyc[i] = cyc;
          exp_q[i].push_back(smul(aa[i], ba[i]));
          rr       = i;
          prev_acc = 1;
          last_a   = aa[i];
          last_b   = ba[i];
        end
      end
      if (prev_acc) m_issue++;
      if ((|bus.req_valid) && bus.req_ready == '0) m_stall++;
    end
  end

  // One cycle: drop accepted requests, then raise wanted lanes with new data.
  task automatic step(input logic [NREQ-1:0] want, input logic [NREQ-1:0] r);
    logic [NREQ-1:0] acc;
    @(negedge sys_clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) va[i] = 1'b0;
      if (!va[i] && want[i]) begin
        va[i] = 1'b1;
        aa[i] = 16'($urandom);
        ba[i] = 16'($urandom);
      end
    end
    rdy = r;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    va[i] = 1'b1;
    aa[i] = a;
    ba[i] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1;
    rdy     = '1;
    va      = '1;
    for (int i = 0; i < NREQ; i++) begin
      aa[i] = 16'($urandom);
      ba[i] = 16'($urandom);
    end
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (20) step('0, '1);

    // Directed products, including the signed corners.
    set_op(0, 16'h7FFF, 16'h8000);
    repeat (8) step('0, '1);
    set_op(0, 16'h8000, 16'h8000);
    set_op(1, 16'hFFFF, 16'h0001);
    repeat (8) step('0, '1);

    // Fairness: everybody always requesting.
    repeat (40) step('1, '1);
    // Backpressure on requester 1.
    repeat (20) step('1, 4'b1101);
    repeat (20) step('1, '1);
    // Random traffic and backpressure.
    repeat (400) step(NREQ'($urandom), NREQ'($urandom));
    repeat (20) step('0, '1);

    // Reset while requesters 2 and 3 are in flight.
    set_op(2, 16'h1234, 16'h0042);
    set_op(3, 16'h8001, 16'h7FFE);
    for (int n = 0; n < 10 && va != '0; n++) step('0, '1);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (40) step('1, '1);

    for (int n = 0; n < 50 && (va != '0 || busy != '0); n++) step('0, '1);
    @(negedge sys_clk);
    chk("drain_rsp_valid", bus.rsp_valid, '0);
    chk("drain_req_ready", bus.req_ready, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
